// File: rtl/isolde_decoder_pkg.sv
// Opcode encoding shared by the ISOLDE decoder and its downstream consumers.
package isolde_decoder_pkg;

    typedef enum logic [3:0] {
        ISOLDE_OP_NOP    = 4'd0,
        ISOLDE_OP_GEMM   = 4'd1,
        ISOLDE_OP_CONV2D = 4'd2,
        ISOLDE_OP_VLOAD  = 4'd3,
        ISOLDE_OP_VSTORE = 4'd4
    } isolde_opcode_e;

endpackage

// File: rtl/isolde_issue_pkg.sv
// Issue-queue entry layout and default sizing.
package isolde_issue_pkg;

    import isolde_decoder_pkg::*;
    import isolde_register_file_pkg::*;

    localparam int IssueDepthDefault = 4;

    typedef struct packed {
        isolde_opcode_e          opcode;
        logic [2:0]              func3;
        logic [1:0]              funct2;
        logic [4:0]              rd;
        logic [4:0]              rs1;
        logic [4:0]              rs2;
        logic [4:0]              rs3;
        logic [RegAddrWidth-1:0] vrs4;
        logic [RegAddrWidth-1:0] vrs5;
    } isolde_issue_entry_t;

endpackage

// File: rtl/isolde_register_file_pkg.sv
// Geometry of the ISOLDE vector register file.
package isolde_register_file_pkg;

    localparam int RegAddrWidth = 5;

endpackage

// File: rtl/isolde_sync_fifo.sv
// Generic single-clock FIFO: register storage, wrapping pointers, occupancy.
// Flush clears pointers and occupancy and wins over push/pop in the same cycle.
// Callers must not push when full or pop when empty.
module isolde_sync_fifo #(
    parameter int  Depth = 4,
    parameter type T     = logic
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  T                           wdata,
    output T                           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(Depth+1)-1:0] count
);

    localparam int AW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CW = $clog2(Depth + 1);

    T              mem [Depth];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;

    // Storage, pointer and occupancy update; pointers wrap naturally (Depth is a power of two).
    // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
    // NOTE: storage is reset on purpose: the head output is read straight from it and must be zero out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < Depth; i++) begin
                mem[i] <= '0;
            end
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (!push && pop) begin
                count <= count - CW'(1);
            end
        end
    end

    assign rdata = mem[rptr];
    assign full  = (count == CW'(Depth));
    assign empty = (count == '0);

endmodule

// File: rtl/isolde_issue_queue.sv
// In-order issue queue between the ISOLDE decoder and execution block.
// Head valid/entry come only from registered state, so there is no path
// from exec_accept_i back to iss_valid_o through the execution block.
module isolde_issue_queue
    import isolde_issue_pkg::*;
#(
    parameter int Depth    = IssueDepthDefault,
    parameter int CntWidth = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       dec_valid_i,
    output logic                       dec_ready_o,
    input  isolde_issue_entry_t        dec_entry_i,
    output logic                       iss_valid_o,
    output isolde_issue_entry_t        iss_entry_o,
    input  logic                       exec_accept_i,
    output logic [$clog2(Depth+1)-1:0] occupancy_o,
    output logic [CntWidth-1:0]        issued_cnt_o,
    output logic                       err_o
);

    logic full;
    logic empty;
    logic push;
    logic pop;

    // Ready and valid depend on registered occupancy only: a pop while full frees the slot next cycle.
    assign dec_ready_o = !full;
    assign iss_valid_o = !empty;

    // Flush suppresses both handshakes for the cycle it is asserted.
    assign push = dec_valid_i && !full && !flush_i;
    assign pop  = exec_accept_i && !empty && !flush_i;

    isolde_sync_fifo #(
        .Depth (Depth),
        .T     (isolde_issue_entry_t)
    ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .flush (flush_i),
        .push  (push),
        .pop   (pop),
        .wdata (dec_entry_i),
        .rdata (iss_entry_o),
        .full  (full),
        .empty (empty),
        .count (occupancy_o)
    );

    // Issued counter (wrapping) and sticky protocol-error flag; neither is touched by flush.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            issued_cnt_o <= '0;
            err_o        <= 1'b0;
        end else begin
            if (pop) begin
                issued_cnt_o <= issued_cnt_o + CntWidth'(1);
            end
            if ((exec_accept_i && empty) || (dec_valid_i && full)) begin
                err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_isolde_issue_queue.sv
// Directed bench for isolde_issue_queue (Depth=4, CntWidth=16).
module tb_isolde_issue_queue;

    import isolde_decoder_pkg::*;
    import isolde_issue_pkg::*;

    localparam int Depth    = 4;
    localparam int CntWidth = 16;

    logic                       clk_i = 1'b0;
    logic                       rst_i;
    logic                       flush_i;
    logic                       dec_valid_i;
    logic                       dec_ready_o;
    isolde_issue_entry_t        dec_entry_i;
    logic                       iss_valid_o;
    isolde_issue_entry_t        iss_entry_o;
    logic                       exec_accept_i;
    logic [$clog2(Depth+1)-1:0] occupancy_o;
    logic [CntWidth-1:0]        issued_cnt_o;
    logic                       err_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    isolde_issue_queue #(
        .Depth    (Depth),
        .CntWidth (CntWidth)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .flush_i       (flush_i),
        .dec_valid_i   (dec_valid_i),
        .dec_ready_o   (dec_ready_o),
        .dec_entry_i   (dec_entry_i),
        .iss_valid_o   (iss_valid_o),
        .iss_entry_o   (iss_entry_o),
        .exec_accept_i (exec_accept_i),
        .occupancy_o   (occupancy_o),
        .issued_cnt_o  (issued_cnt_o),
        .err_o         (err_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic isolde_issue_entry_t mk(input isolde_opcode_e op, input logic [2:0] f3,
                                               input logic [4:0] rd, input logic [4:0] rs1,
                                               input logic [4:0] rs2);
        isolde_issue_entry_t e;
        e        = '0;
        e.opcode = op;
        e.func3  = f3;
        e.rd     = rd;
        e.rs1    = rs1;
        e.rs2    = rs2;
        return e;
    endfunction

    task automatic push_one(input logic [4:0] rd);
        dec_valid_i = 1'b1;
        dec_entry_i = mk(ISOLDE_OP_CONV2D, 3'b001, rd, 5'd0, 5'd0);
        tick();
        dec_valid_i = 1'b0;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_ready"}, 64'(dec_ready_o), 64'd1);
        check({pfx, "_valid"}, 64'(iss_valid_o), 64'd0);
        check({pfx, "_entry"}, 64'(iss_entry_o), 64'd0);
        check({pfx, "_occ"},   64'(occupancy_o), 64'd0);
        check({pfx, "_cnt"},   64'(issued_cnt_o), 64'd0);
        check({pfx, "_err"},   64'(err_o), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        isolde_issue_entry_t gemm;
        int q[$];
        int mocc;
        int npush;
        int npop;

        rst_i         = 1'b1;
        flush_i       = 1'b0;
        dec_valid_i   = 1'b0;
        dec_entry_i   = '0;
        exec_accept_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b0;
        tick();
        check_reset_outputs("rst");

        // Single gemm instruction: visible after the push edge, gone after accept.
        gemm        = mk(ISOLDE_OP_GEMM, 3'b010, 5'd0, 5'd5, 5'd6);
        dec_valid_i = 1'b1;
        dec_entry_i = gemm;
        tick();
        dec_valid_i = 1'b0;
        check("single_valid", 64'(iss_valid_o), 64'd1);
        check("single_entry", 64'(iss_entry_o), 64'(gemm));
        check("single_occ",   64'(occupancy_o), 64'd1);
        exec_accept_i = 1'b1;
        tick();
        exec_accept_i = 1'b0;
        check("single_valid_after", 64'(iss_valid_o), 64'd0);
        check("single_cnt",         64'(issued_cnt_o), 64'd1);

        // Fill to Depth with no accepts, then overflow attempt.
        for (int i = 1; i <= 4; i++) push_one(5'(i));
        check("fill_occ",   64'(occupancy_o), 64'd4);
        check("fill_ready", 64'(dec_ready_o), 64'd0);
        check("fill_err0",  64'(err_o), 64'd0);
        push_one(5'd5);
        check("ovf_err",  64'(err_o), 64'd1);
        check("ovf_occ",  64'(occupancy_o), 64'd4);
        check("ovf_head", 64'(iss_entry_o.rd), 64'd1);
        // Accept while full with a push offered: push is refused, room appears next cycle.
        dec_valid_i   = 1'b1;
        dec_entry_i   = mk(ISOLDE_OP_CONV2D, 3'b001, 5'd6, 5'd0, 5'd0);
        exec_accept_i = 1'b1;
        tick();
        dec_valid_i   = 1'b0;
        exec_accept_i = 1'b0;
        check("full_pop_occ",   64'(occupancy_o), 64'd3);
        check("full_pop_ready", 64'(dec_ready_o), 64'd1);
        check("full_pop_cnt",   64'(issued_cnt_o), 64'd2);
        for (int i = 2; i <= 4; i++) begin
            check("drain_order", 64'(iss_entry_o.rd), 64'(i));
            exec_accept_i = 1'b1;
            tick();
            exec_accept_i = 1'b0;
        end
        check("drain_occ", 64'(occupancy_o), 64'd0);
        check("drain_cnt", 64'(issued_cnt_o), 64'd5);

        // Stream rd=1..10, accepting on odd cycles; model tracks occupancy and order.
        mocc  = 0;
        npush = 0;
        npop  = 0;
        for (int cyc = 0; cyc < 60 && npop < 10; cyc++) begin
            bit do_push;
            bit do_pop;
            do_push = (npush < 10) && (mocc < Depth);
            do_pop  = (cyc % 2 == 1) && (mocc > 0);
            check("stream_ready", 64'(dec_ready_o), 64'(mocc < Depth));
            check("stream_valid", 64'(iss_valid_o), 64'(mocc > 0));
            if (do_pop) begin
                check("stream_order", 64'(iss_entry_o.rd), 64'(q[0]));
                void'(q.pop_front());
                npop++;
            end
            dec_valid_i   = do_push;
            dec_entry_i   = mk(ISOLDE_OP_CONV2D, 3'b011, 5'(npush + 1), 5'd1, 5'd2);
            exec_accept_i = do_pop;
            if (do_push) begin
                q.push_back(npush + 1);
                npush++;
            end
            tick();
            mocc = mocc + int'(do_push) - int'(do_pop);
            check("stream_occ", 64'(occupancy_o), 64'(mocc));
        end
        dec_valid_i   = 1'b0;
        exec_accept_i = 1'b0;
        check("stream_done", 64'(npop), 64'd10);
        check("stream_final_occ", 64'(occupancy_o), 64'd0);
        check("stream_cnt", 64'(issued_cnt_o), 64'd15);

        // Simultaneous push and pop at occupancy 1.
        push_one(5'd20);
        check("sim_pre_head", 64'(iss_entry_o.rd), 64'd20);
        dec_valid_i   = 1'b1;
        dec_entry_i   = mk(ISOLDE_OP_NOP, 3'b000, 5'd21, 5'd0, 5'd0);
        exec_accept_i = 1'b1;
        tick();
        dec_valid_i   = 1'b0;
        exec_accept_i = 1'b0;
        check("sim_occ",   64'(occupancy_o), 64'd1);
        check("sim_valid", 64'(iss_valid_o), 64'd1);
        check("sim_head",  64'(iss_entry_o.rd), 64'd21);
        check("sim_cnt",   64'(issued_cnt_o), 64'd16);

        // Flush at occupancy 3 with push and accept in the same cycle.
        push_one(5'd22);
        push_one(5'd23);
        check("flush_pre_occ", 64'(occupancy_o), 64'd3);
        flush_i       = 1'b1;
        dec_valid_i   = 1'b1;
        dec_entry_i   = mk(ISOLDE_OP_GEMM, 3'b010, 5'd24, 5'd0, 5'd0);
        exec_accept_i = 1'b1;
        tick();
        flush_i       = 1'b0;
        dec_valid_i   = 1'b0;
        exec_accept_i = 1'b0;
        check("flush_occ",   64'(occupancy_o), 64'd0);
        check("flush_valid", 64'(iss_valid_o), 64'd0);
        check("flush_ready", 64'(dec_ready_o), 64'd1);
        check("flush_cnt",   64'(issued_cnt_o), 64'd16);
        check("flush_err",   64'(err_o), 64'd1);

        // Reset mid-stream at occupancy 2 with err set.
        push_one(5'd30);
        push_one(5'd31);
        check("mid_pre_occ", 64'(occupancy_o), 64'd2);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check_reset_outputs("mid_rst");

        // Accept while empty is a protocol error and changes nothing else.
        exec_accept_i = 1'b1;
        tick();
        exec_accept_i = 1'b0;
        check("empty_acc_err", 64'(err_o), 64'd1);
        check("empty_acc_occ", 64'(occupancy_o), 64'd0);
        check("empty_acc_cnt", 64'(issued_cnt_o), 64'd0);

        // Queue restarts cleanly from pointer 0.
        push_one(5'd9);
        check("restart_head", 64'(iss_entry_o),
              64'(mk(ISOLDE_OP_CONV2D, 3'b001, 5'd9, 5'd0, 5'd0)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
